// File: rtl/uart_to_sha_buffer.sv
// Purpose: packs a UART byte stream, big-endian, into 512-bit blocks for a SHA core.
// Latency: sha_block and block_ready update on the edge that accepts the 64th byte.
// Backpressure: none; every strobed byte is taken, and block_ready is a level flag, not a handshake.
module uart_to_sha_buffer #(
   parameter int BLOCK_BYTES = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [7:0]               data_in,
   input  logic                     data_ready,
   output logic [BLOCK_BYTES*8-1:0] sha_block,
   output logic                     block_ready
);

   localparam int BLOCK_BITS = BLOCK_BYTES * 8;
   localparam int CNT_W      = $clog2(BLOCK_BYTES);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_BYTES - 1);

   // Partial block under construction, kept apart from the published sha_block.
   logic [BLOCK_BITS-1:0] assembly;
   logic [CNT_W-1:0]      byte_cnt;
   logic                  last_byte;

   assign last_byte = (byte_cnt == LAST_IDX);

   // Byte position within the current block; the power-of-two width wraps 63 -> 0 by itself.
   always_ff @(posedge clk) begin
      if (rst) begin
         byte_cnt <= '0;
      end else if (data_ready) begin
         byte_cnt <= byte_cnt + 1'b1;
      end
   end

   // Drop each accepted byte into its big-endian slot: byte k lands at [511-8k -: 8].
   always_ff @(posedge clk) begin
      if (rst) begin
         assembly <= '0;
      end else if (data_ready) begin
         for (int k = 0; k < BLOCK_BYTES; k++) begin
            if (byte_cnt == CNT_W'(k)) begin
               assembly[BLOCK_BITS-8-8*k +: 8] <= data_in;
            end
         end
      end
   end

   // Publish the finished block on the 64th byte; the first byte of the next block retires the flag.
   // The last byte is taken straight from data_in, because its assembly slot is only written on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         sha_block   <= '0;
         block_ready <= 1'b0;
      end else if (data_ready) begin
         block_ready <= last_byte;
         if (last_byte) begin
            sha_block <= {assembly[BLOCK_BITS-1:8], data_in};
         end
      end
   end

endmodule

// File: tb/tb_uart_to_sha_buffer.sv
// Bench for uart_to_sha_buffer: table of whole-block vectors plus hand sequences for
// hold, supersede, back-to-back streaming, mid-block reset and idle-input cases.
// Clock period is 10 ns; inputs change on the falling edge and outputs are sampled there too.
module tb_uart_to_sha_buffer;

   logic         clk;
   logic         rst;
   logic [7:0]   data_in;
   logic         data_ready;
   logic [511:0] sha_block;
   logic         block_ready;

   int n_tests;
   int n_fail;

   localparam logic [511:0] INC_01 = {
      128'h0102030405060708090a0b0c0d0e0f10,
      128'h1112131415161718191a1b1c1d1e1f20,
      128'h2122232425262728292a2b2c2d2e2f30,
      128'h3132333435363738393a3b3c3d3e3f40};

   localparam logic [511:0] INC_41 = {
      128'h4142434445464748494a4b4c4d4e4f50,
      128'h5152535455565758595a5b5c5d5e5f60,
      128'h6162636465666768696a6b6c6d6e6f70,
      128'h7172737475767778797a7b7c7d7e7f80};

   localparam logic [511:0] ALL_AA = {64{8'hAA}};
   localparam logic [511:0] ALL_11 = {64{8'h11}};
   localparam logic [511:0] ALL_33 = {64{8'h33}};

   typedef struct {
      string        name;
      int           n_bytes;
      logic         inc;
      logic [7:0]   start;
      logic         exp_ready;
      logic [511:0] exp_block;
   } vec_t;

   vec_t vecs[4];

   uart_to_sha_buffer #(.BLOCK_BYTES(64)) dut (
      .clk         (clk),
      .rst         (rst),
      .data_in     (data_in),
      .data_ready  (data_ready),
      .sha_block   (sha_block),
      .block_ready (block_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk_bit(input string name, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, want %b", name, act, exp);
      end
   endtask

   task automatic chk_blk(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   // Hold rst for n rising edges with data_ready low; returns on a falling edge with rst low.
   task automatic do_reset(input int n);
      @(negedge clk);
      rst        = 1'b1;
      data_ready = 1'b0;
      repeat (n) @(negedge clk);
      rst = 1'b0;
   endtask

   // One-cycle strobe followed by an idle cycle; returns on the falling edge just after the accept.
   task automatic send(input logic [7:0] b);
      @(negedge clk);
      data_in    = b;
      data_ready = 1'b1;
      @(negedge clk);
      data_ready = 1'b0;
   endtask

   initial begin
      n_tests    = 0;
      n_fail     = 0;
      rst        = 1'b1;
      data_in    = 8'h00;
      data_ready = 1'b0;

      vecs[0] = '{"inc64",      64, 1'b1, 8'h01, 1'b1, INC_01};
      vecs[1] = '{"inc63",      63, 1'b1, 8'h01, 1'b0, 512'h0};
      vecs[2] = '{"aa64",       64, 1'b0, 8'hAA, 1'b1, ALL_AA};
      vecs[3] = '{"inc64_at41", 64, 1'b1, 8'h41, 1'b1, INC_41};

      // Reset state after two reset cycles
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk_bit("reset_ready", block_ready, 1'b0);
      chk_blk("reset_block", sha_block, 512'h0);

      // Table-driven whole-block vectors, each from a fresh reset
      for (int v = 0; v < 4; v++) begin
         do_reset(1);
         for (int j = 0; j < vecs[v].n_bytes; j++) begin
            send(vecs[v].inc ? 8'(int'(vecs[v].start) + j) : vecs[v].start);
         end
         chk_bit({vecs[v].name, "_ready"}, block_ready, vecs[v].exp_ready);
         chk_blk({vecs[v].name, "_block"}, sha_block, vecs[v].exp_block);
      end

      // Completion is held for 50 ns, then 100 idle cycles of random data_in change nothing
      do_reset(1);
      for (int j = 0; j < 63; j++) send(8'(j + 1));
      chk_bit("hold_before_last", block_ready, 1'b0);
      send(8'h40);
      chk_bit("hold_ready_now", block_ready, 1'b1);
      #50;
      chk_bit("hold_ready_50ns", block_ready, 1'b1);
      chk_blk("hold_block_50ns", sha_block, INC_01);
      for (int j = 0; j < 100; j++) begin
         @(negedge clk);
         data_in    = 8'($urandom_range(255, 0));
         data_ready = 1'b0;
      end
      @(negedge clk);
      chk_bit("idle_ready", block_ready, 1'b1);
      chk_blk("idle_block", sha_block, INC_01);
      // Counter must still be at 0: exactly 64 fresh bytes complete a clean block
      send(8'h33);
      chk_bit("idle_next_clears", block_ready, 1'b0);
      for (int j = 1; j < 63; j++) send(8'h33);
      chk_bit("idle_63_not_ready", block_ready, 1'b0);
      send(8'h33);
      chk_blk("idle_next_block", sha_block, ALL_33);

      // 64 x 0xAA then 0x55: flag drops, published block untouched
      do_reset(1);
      for (int j = 0; j < 64; j++) send(8'hAA);
      chk_bit("supersede_ready_pre", block_ready, 1'b1);
      send(8'h55);
      chk_bit("supersede_ready", block_ready, 1'b0);
      chk_blk("supersede_block", sha_block, ALL_AA);

      // 128 back-to-back bytes 0x01..0x80 with data_ready held high
      do_reset(1);
      for (int i = 0; i < 128; i++) begin
         @(negedge clk);
         if (i == 64) begin
            chk_bit("b2b_ready_first", block_ready, 1'b1);
            chk_blk("b2b_block_first", sha_block, INC_01);
         end
         if (i == 65) begin
            chk_bit("b2b_ready_fall", block_ready, 1'b0);
            chk_blk("b2b_block_kept", sha_block, INC_01);
         end
         data_in    = 8'(i + 1);
         data_ready = 1'b1;
      end
      @(negedge clk);
      data_ready = 1'b0;
      chk_bit("b2b_ready_second", block_ready, 1'b1);
      chk_blk("b2b_block_second", sha_block, INC_41);

      // Reset clears a published block
      do_reset(1);
      chk_bit("rst_clears_ready", block_ready, 1'b0);
      chk_blk("rst_clears_block", sha_block, 512'h0);

      // 20 bytes, then a reset cycle with data_ready also high, then 64 x 0x11
      for (int j = 0; j < 20; j++) send(8'hEE);
      @(negedge clk);
      rst        = 1'b1;
      data_in    = 8'h77;
      data_ready = 1'b1;
      @(negedge clk);
      rst        = 1'b0;
      data_ready = 1'b0;
      chk_bit("midrst_ready", block_ready, 1'b0);
      chk_blk("midrst_block", sha_block, 512'h0);
      for (int j = 0; j < 63; j++) send(8'h11);
      chk_bit("midrst_63_not_ready", block_ready, 1'b0);
      send(8'h11);
      chk_bit("midrst_64_ready", block_ready, 1'b1);
      chk_blk("midrst_64_block", sha_block, ALL_11);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
